// File: rtl/tpu_issue_ctrl_if.sv
// Instruction-stream and functional-unit dispatch bundle for tpu_issue_ctrl.
//   instr_valid/instr_ready/instr_in : instruction stream handshake
//   mma/ten/mem_start, u_op, u_src*  : dispatch pulse and operand fields
//   mma/ten/mem_done                 : completion pulses from the units
// master = stream source / unit side, slave = the issue controller.
interface tpu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_in;
    logic        mma_start;
    logic        ten_start;
    logic        mem_start;
    logic [7:0]  u_op;
    logic [3:0]  u_srcA;
    logic [3:0]  u_srcB;
    logic [3:0]  u_dst;
    logic        mma_done;
    logic        ten_done;
    logic        mem_done;

    modport master (
        output instr_valid, instr_in, mma_done, ten_done, mem_done,
        input  instr_ready, mma_start, ten_start, mem_start,
               u_op, u_srcA, u_srcB, u_dst
    );

    modport slave (
        input  instr_valid, instr_in, mma_done, ten_done, mem_done,
        output instr_ready, mma_start, ten_start, mem_start,
               u_op, u_srcA, u_srcB, u_dst
    );
endinterface

// File: rtl/tpu_issue_ctrl.sv
// In-order single-issue scheduler: decodes an instruction into a one-entry
// hold register, checks register scoreboard and unit busy flags, dispatches
// with a one-cycle start pulse and retires on the unit's done pulse.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : stream handshake, dispatch outputs, done inputs
//   illegal_op    : pulse when an undecodable opcode is dropped
//   idle          : hold empty, no unit busy, scoreboard clear
//   issued_count  : saturating count of dispatched instructions
//   stall_count   : saturating count of blocked cycles
module tpu_issue_ctrl #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    tpu_issue_ctrl_if.slave    bus,
    output logic               illegal_op,
    output logic               idle,
    output logic [CNT_W-1:0]   issued_count,
    output logic [CNT_W-1:0]   stall_count
);
    localparam int unsigned REG_W = $clog2(NREGS);
    localparam int unsigned NUNIT = 3;
    localparam logic [1:0]  CLS_MMA = 2'd0;
    localparam logic [1:0]  CLS_TEN = 2'd1;
    localparam logic [1:0]  CLS_MEM = 2'd2;

    typedef enum logic {S_EMPTY, S_FULL} hold_state_e;

    hold_state_e                   state_q, state_d;
    logic [7:0]                    hold_op_q, hold_op_d;
    logic [REG_W-1:0]              hold_srca_q, hold_srca_d;
    logic [REG_W-1:0]              hold_srcb_q, hold_srcb_d;
    logic [REG_W-1:0]              hold_dst_q, hold_dst_d;
    logic [1:0]                    hold_cls_q, hold_cls_d;
    logic [NUNIT-1:0]              busy_q, busy_d;
    logic [NREGS-1:0]              pend_q, pend_d;
    logic [NUNIT-1:0][REG_W-1:0]   unit_dst_q, unit_dst_d;
    logic                          mma_start_q, mma_start_d;
    logic                          ten_start_q, ten_start_d;
    logic                          mem_start_q, mem_start_d;
    logic [7:0]                    u_op_q, u_op_d;
    logic [REG_W-1:0]              u_srca_q, u_srca_d;
    logic [REG_W-1:0]              u_srcb_q, u_srcb_d;
    logic [REG_W-1:0]              u_dst_q, u_dst_d;
    logic                          illegal_op_q, illegal_op_d;
    logic                          idle_q, idle_d;
    logic [CNT_W-1:0]              issued_q, issued_d;
    logic [CNT_W-1:0]              stall_q, stall_d;

    logic                          dec_legal_c;
    logic [1:0]                    dec_cls_c;
    logic                          class_busy_c;
    logic                          issue_fire_c;
    logic                          ready_c;
    logic                          accept_c;
    logic                          load_c;
    logic [NUNIT-1:0]              done_c;

    // Opcode decode of the offered instruction
    always_comb begin
        dec_legal_c = 1'b1;
        dec_cls_c   = CLS_MMA;
        case (bus.instr_in[31:24])
            8'h03, 8'h04, 8'h30: dec_cls_c = CLS_MMA;
            8'h20, 8'h21:        dec_cls_c = CLS_TEN;
            8'h10, 8'h11:        dec_cls_c = CLS_MEM;
            default:             dec_legal_c = 1'b0;
        endcase
    end

    // Structural hazard on the held instruction's unit
    always_comb begin
        case (hold_cls_q)
            CLS_MMA: class_busy_c = busy_q[0];
            CLS_TEN: class_busy_c = busy_q[1];
            CLS_MEM: class_busy_c = busy_q[2];
            default: class_busy_c = 1'b1;
        endcase
    end

    // Hazard terms use registered state only, so a done this cycle unblocks next cycle
    assign issue_fire_c = (state_q == S_FULL) && !class_busy_c &&
                          !pend_q[hold_srca_q] && !pend_q[hold_srcb_q] && !pend_q[hold_dst_q];
    assign ready_c      = (state_q == S_EMPTY) || issue_fire_c;
    assign accept_c     = bus.instr_valid && ready_c;
    assign load_c       = accept_c && dec_legal_c;
    assign done_c       = {bus.mem_done, bus.ten_done, bus.mma_done};

    // Next-state, scoreboard and output logic
    always_comb begin
        state_d      = state_q;
        hold_op_d    = hold_op_q;
        hold_srca_d  = hold_srca_q;
        hold_srcb_d  = hold_srcb_q;
        hold_dst_d   = hold_dst_q;
        hold_cls_d   = hold_cls_q;
        busy_d       = busy_q;
        pend_d       = pend_q;
        unit_dst_d   = unit_dst_q;
        mma_start_d  = 1'b0;
        ten_start_d  = 1'b0;
        mem_start_d  = 1'b0;
        u_op_d       = u_op_q;
        u_srca_d     = u_srca_q;
        u_srcb_d     = u_srcb_q;
        u_dst_d      = u_dst_q;
        illegal_op_d = accept_c && !dec_legal_c;
        issued_d     = issued_q;
        stall_d      = stall_q;

        // Retire: spurious done on an idle unit is ignored
        for (int u = 0; u < int'(NUNIT); u++) begin
            if (done_c[u] && busy_q[u]) begin
                busy_d[u]               = 1'b0;
                pend_d[unit_dst_q[u]]   = 1'b0;
            end
        end

        if (issue_fire_c) begin
            mma_start_d            = (hold_cls_q == CLS_MMA);
            ten_start_d            = (hold_cls_q == CLS_TEN);
            mem_start_d            = (hold_cls_q == CLS_MEM);
            u_op_d                 = hold_op_q;
            u_srca_d               = hold_srca_q;
            u_srcb_d               = hold_srcb_q;
            u_dst_d                = hold_dst_q;
            busy_d[hold_cls_q]     = 1'b1;
            pend_d[hold_dst_q]     = 1'b1;
            unit_dst_d[hold_cls_q] = hold_dst_q;
            if (issued_q != '1) issued_d = issued_q + CNT_W'(1);
        end else if (state_q == S_FULL) begin
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end

        case (state_q)
            S_EMPTY: if (load_c) state_d = S_FULL;
            S_FULL:  if (issue_fire_c && !load_c) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase

        if (load_c) begin
            hold_op_d   = bus.instr_in[31:24];
            hold_srca_d = REG_W'(bus.instr_in[19:16]);
            hold_srcb_d = REG_W'(bus.instr_in[15:12]);
            hold_dst_d  = REG_W'(bus.instr_in[11:8]);
            hold_cls_d  = dec_cls_c;
        end

        idle_d = (state_d == S_EMPTY) && (busy_d == '0) && (pend_d == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            hold_op_q    <= '0;
            hold_srca_q  <= '0;
            hold_srcb_q  <= '0;
            hold_dst_q   <= '0;
            hold_cls_q   <= CLS_MMA;
            busy_q       <= '0;
            pend_q       <= '0;
            unit_dst_q   <= '0;
            mma_start_q  <= 1'b0;
            ten_start_q  <= 1'b0;
            mem_start_q  <= 1'b0;
            u_op_q       <= '0;
            u_srca_q     <= '0;
            u_srcb_q     <= '0;
            u_dst_q      <= '0;
            illegal_op_q <= 1'b0;
            idle_q       <= 1'b1;
            issued_q     <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_op_q    <= hold_op_d;
            hold_srca_q  <= hold_srca_d;
            hold_srcb_q  <= hold_srcb_d;
            hold_dst_q   <= hold_dst_d;
            hold_cls_q   <= hold_cls_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            unit_dst_q   <= unit_dst_d;
            mma_start_q  <= mma_start_d;
            ten_start_q  <= ten_start_d;
            mem_start_q  <= mem_start_d;
            u_op_q       <= u_op_d;
            u_srca_q     <= u_srca_d;
            u_srcb_q     <= u_srcb_d;
            u_dst_q      <= u_dst_d;
            illegal_op_q <= illegal_op_d;
            idle_q       <= idle_d;
            issued_q     <= issued_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.instr_ready = ready_c;
    assign bus.mma_start   = mma_start_q;
    assign bus.ten_start   = ten_start_q;
    assign bus.mem_start   = mem_start_q;
    assign bus.u_op        = u_op_q;
    assign bus.u_srcA      = 4'(u_srca_q);
    assign bus.u_srcB      = 4'(u_srcb_q);
    assign bus.u_dst       = 4'(u_dst_q);
    assign illegal_op      = illegal_op_q;
    assign idle            = idle_q;
    assign issued_count    = issued_q;
    assign stall_count     = stall_q;
endmodule

// File: tb/tb_tpu_issue_ctrl.sv
// Self-checking bench for tpu_issue_ctrl: directed scenarios followed by
// random traffic, all outputs compared against a transaction-level model.
module tb_tpu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        illegal_op;
    logic        idle;
    logic [15:0] issued_count;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    tpu_issue_ctrl_if bus();

    tpu_issue_ctrl #(.NREGS(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .illegal_op   (illegal_op),
        .idle         (idle),
        .issued_count (issued_count),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: held instruction, per-unit in-flight dst (-1 = free),
    // per-register pending flag, counters and expected pulse outputs.
    bit m_hold;
    int m_op, m_a, m_b, m_d;
    int m_unit[3];
    int m_pend[16];
    int m_issued, m_stall;
    bit m_illegal, m_acc;
    int m_start_unit;
    int m_uop, m_ua, m_ub, m_ud;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cls_of(input int op);
        case (op)
            'h03, 'h04, 'h30: return 0;
            'h20, 'h21:       return 1;
            'h10, 'h11:       return 2;
            default:          return -1;
        endcase
    endfunction

    function automatic bit m_fire();
        int c;
        if (!m_hold) return 1'b0;
        c = cls_of(m_op);
        return (m_unit[c] < 0) && (m_pend[m_a] == 0) && (m_pend[m_b] == 0) && (m_pend[m_d] == 0);
    endfunction

    function automatic bit m_idle();
        bit r;
        r = !m_hold;
        for (int u = 0; u < 3; u++) if (m_unit[u] >= 0) r = 1'b0;
        for (int i = 0; i < 16; i++) if (m_pend[i] != 0) r = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_op = 0; m_a = 0; m_b = 0; m_d = 0;
        for (int u = 0; u < 3; u++) m_unit[u] = -1;
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_issued = 0; m_stall = 0; m_illegal = 0; m_acc = 0;
        m_start_unit = -1;
        m_uop = 0; m_ua = 0; m_ub = 0; m_ud = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        bit fire, rdy;
        int c, nc;
        logic [2:0] dn;
        if (rst) begin
            model_reset();
            return;
        end
        fire = m_fire();
        c    = m_hold ? cls_of(m_op) : -1;
        rdy  = !m_hold || fire;
        nc   = cls_of(int'(bus.instr_in[31:24]));
        m_acc     = bus.instr_valid && rdy;
        m_illegal = m_acc && (nc < 0);
        dn = {bus.mem_done, bus.ten_done, bus.mma_done};
        for (int u = 0; u < 3; u++) begin
            if (dn[u] && m_unit[u] >= 0) begin
                m_pend[m_unit[u]] = 0;
                m_unit[u] = -1;
            end
        end
        m_start_unit = -1;
        if (fire) begin
            m_start_unit = c;
            m_uop = m_op; m_ua = m_a; m_ub = m_b; m_ud = m_d;
            m_unit[c] = m_d;
            m_pend[m_d] = 1;
            if (m_issued < 65535) m_issued++;
            m_hold = 0;
        end else if (m_hold) begin
            if (m_stall < 65535) m_stall++;
        end
        if (m_acc && nc >= 0) begin
            m_hold = 1;
            m_op = int'(bus.instr_in[31:24]);
            m_a  = int'(bus.instr_in[19:16]);
            m_b  = int'(bus.instr_in[15:12]);
            m_d  = int'(bus.instr_in[11:8]);
        end
    endtask

    task automatic compare_outputs();
        check("mma_start", bus.mma_start, m_start_unit == 0);
        check("ten_start", bus.ten_start, m_start_unit == 1);
        check("mem_start", bus.mem_start, m_start_unit == 2);
        if (m_start_unit >= 0) begin
            check("u_op",   bus.u_op,   m_uop);
            check("u_srcA", bus.u_srcA, m_ua);
            check("u_srcB", bus.u_srcB, m_ub);
            check("u_dst",  bus.u_dst,  m_ud);
        end
        check("illegal_op",   illegal_op,   m_illegal);
        check("idle",         idle,         m_idle());
        check("issued_count", issued_count, m_issued);
        check("stall_count",  stall_count,  m_stall);
    endtask

    // One clock: inputs already driven; ready checked mid-cycle, outputs after the edge
    task automatic step();
        @(negedge clk);
        check("instr_ready", bus.instr_ready, !m_hold || m_fire());
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic cycle(input bit v, input logic [31:0] ins, input logic [2:0] dn);
        bus.instr_valid = v;
        bus.instr_in    = ins;
        bus.mma_done    = dn[0];
        bus.ten_done    = dn[1];
        bus.mem_done    = dn[2];
        step();
    endtask

    // Offer one instruction until accepted, then deassert valid
    task automatic send(input logic [31:0] ins);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle(1'b1, ins, 3'b000);
            ok = m_acc;
        end
        bus.instr_valid = 1'b0;
        check("send_timeout", ok, 1'b1);
    endtask

    // Return done pulses for busy units until everything drains
    task automatic drain();
        logic [2:0] dn;
        for (int i = 0; i < 60 && !m_idle(); i++) begin
            for (int u = 0; u < 3; u++) dn[u] = (m_unit[u] >= 0);
            cycle(1'b0, 32'h0, dn);
        end
        cycle(1'b0, 32'h0, 3'b000);
        check("drain_idle", idle, 1'b1);
    endtask

    initial begin
        logic [7:0]  ops [10];
        logic [31:0] ins;
        logic [2:0]  dn;
        int base;
        ops = '{8'h03, 8'h04, 8'h30, 8'h20, 8'h21, 8'h10, 8'h11, 8'h7F, 8'h00, 8'h05};

        model_reset();
        rst = 1'b1;
        cycle(1'b0, 32'h0, 3'b000);
        cycle(1'b0, 32'h0, 3'b000);
        rst = 1'b0;
        cycle(1'b0, 32'h0, 3'b000);
        check("rst_ready",  bus.instr_ready, 1'b1);
        check("rst_idle",   idle, 1'b1);
        check("rst_issued", issued_count, 16'd0);
        check("rst_stall",  stall_count, 16'd0);
        check("rst_uop",    bus.u_op, 8'h00);
        check("rst_udst",   {bus.u_srcA, bus.u_srcB, bus.u_dst}, 12'h000);

        // Single MMA: start one cycle after acceptance
        send(32'h0301_2000);
        check("t1_no_start_yet", bus.mma_start, 1'b0);
        cycle(1'b0, 32'h0, 3'b000);
        check("t1_mma_start", bus.mma_start, 1'b1);
        check("t1_u_op",   bus.u_op, 8'h03);
        check("t1_u_srcA", bus.u_srcA, 4'd1);
        check("t1_u_srcB", bus.u_srcB, 4'd2);
        check("t1_u_dst",  bus.u_dst, 4'd0);
        cycle(1'b0, 32'h0, 3'b000);
        check("t1_pulse_one_cycle", bus.mma_start, 1'b0);
        cycle(1'b0, 32'h0, 3'b001);
        check("t1_idle", idle, 1'b1);
        check("t1_issued", issued_count, 16'd1);

        // Structural/WAW stall with mma_done delayed 5 cycles
        send(32'h0301_2000);
        send(32'h0401_2000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 3'b000);
            check("t2_ready_low", bus.instr_ready, 1'b0);
        end
        cycle(1'b0, 32'h0, 3'b001);
        check("t2_not_yet", bus.mma_start, 1'b0);
        cycle(1'b0, 32'h0, 3'b000);
        check("t2_issue_after_done", bus.mma_start, 1'b1);
        check("t2_u_op", bus.u_op, 8'h04);
        check("t2_stall", stall_count, 16'd6);
        drain();

        // Back-to-back tensor then memory
        send(32'h2001_2300);
        check("t3_ready", bus.instr_ready, 1'b1);
        send(32'h1004_5600);
        check("t3_ten_start", bus.ten_start, 1'b1);
        cycle(1'b0, 32'h0, 3'b000);
        check("t3_mem_start", bus.mem_start, 1'b1);
        drain();

        // RAW on r3 holds the memory op behind the MMA
        base = int'(stall_count);
        send(32'h3001_2300);
        send(32'h1103_4500);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 3'b000);
            check("t4_mem_wait", bus.mem_start, 1'b0);
        end
        cycle(1'b0, 32'h0, 3'b001);
        cycle(1'b0, 32'h0, 3'b000);
        check("t4_mem_start", bus.mem_start, 1'b1);
        check("t4_stall", stall_count, 16'(base + 4));
        drain();

        // Illegal opcode dropped
        base = int'(issued_count);
        send(32'h7F00_0000);
        check("t5_illegal", illegal_op, 1'b1);
        cycle(1'b0, 32'h0, 3'b000);
        check("t5_illegal_pulse", illegal_op, 1'b0);
        check("t5_no_issue", issued_count, 16'(base));
        send(32'h0301_2000);
        cycle(1'b0, 32'h0, 3'b000);
        check("t5_next_issues", bus.mma_start, 1'b1);
        drain();

        // Reset while busy with a stalled instruction held
        send(32'h0301_2000);
        send(32'h0401_2000);
        cycle(1'b0, 32'h0, 3'b000);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 3'b001);
        rst = 1'b0;
        check("t6_idle", idle, 1'b1);
        check("t6_issued", issued_count, 16'd0);
        cycle(1'b0, 32'h0, 3'b001);
        check("t6_late_done_idle", idle, 1'b1);
        send(32'h0301_2000);
        cycle(1'b0, 32'h0, 3'b000);
        check("t6_issue_after_rst", bus.mma_start, 1'b1);
        drain();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            ins[31:24] = ops[$urandom_range(0, 9)];
            ins[19:16] = 4'($urandom_range(0, 7));
            ins[15:12] = 4'($urandom_range(0, 7));
            ins[11:8]  = 4'($urandom_range(0, 7));
            for (int u = 0; u < 3; u++)
                dn[u] = (m_unit[u] >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 9) < 7, ins, dn);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
